// File: rtl/bram_window_ctrl.sv
// Loads one window of samples into a dual-port BRAM (port A), then streams it back out (port B)
// through a 2-entry skid FIFO. Optional checksum compare is enabled by BRAM_WINDOW_CHKSUM_EN.
module bram_window_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int WIN_LEN    = 256
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    output logic                  o_busy,
    output logic                  o_done,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    input  logic [DATA_WIDTH-1:0] i_s_data,
    output logic                  o_m_valid,
    input  logic                  i_m_ready,
    output logic [DATA_WIDTH-1:0] o_m_data,
    output logic                  o_m_last,
`ifdef BRAM_WINDOW_CHKSUM_EN
    output logic                  o_chk_err,
`endif
    output logic                  o_bram_ena,
    output logic                  o_bram_wea,
    output logic [ADDR_WIDTH-1:0] o_bram_addra,
    output logic [DATA_WIDTH-1:0] o_bram_dina,
    output logic                  o_bram_enb,
    output logic                  o_bram_web,
    output logic [ADDR_WIDTH-1:0] o_bram_addrb,
    output logic [DATA_WIDTH-1:0] o_bram_dinb,
    input  logic [DATA_WIDTH-1:0] i_bram_doutb
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] LEN  = CW'(WIN_LEN);
    localparam logic [CW-1:0] LAST = CW'(WIN_LEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_FIN} state_t;

    state_t                         r_state, w_state_nxt;
    logic [CW-1:0]                  r_wr_cnt, r_rd_addr, r_out_cnt;
    logic                           r_inflight;
    logic [1:0][DATA_WIDTH-1:0]     r_fifo;
    logic                           r_wptr, r_rptr;
    logic [1:0]                     r_fcnt;

    logic                           w_start_acc, w_wr, w_issue, w_pop;
    logic                           w_m_valid, w_m_last;
    logic [2:0]                     w_occ;
    logic [DATA_WIDTH-1:0]          w_head;

    assign w_start_acc = (r_state == S_IDLE) && i_start;
    assign w_wr        = (r_state == S_LOAD) && i_s_valid;
    assign w_m_valid   = (r_state == S_READ) && (r_fcnt != 2'd0);
    assign w_pop       = w_m_valid && i_m_ready;
    assign w_m_last    = w_m_valid && (r_out_cnt == LAST);
    assign w_head      = r_fifo[r_rptr];
    // Occupancy after this cycle's pop plus the read whose data lands next cycle.
    assign w_occ       = 3'(r_fcnt) + 3'(r_inflight) - 3'(w_pop);
    assign w_issue     = (r_state == S_READ) && (r_rd_addr < LEN) && (w_occ < 3'd2);

    always_comb begin
        w_state_nxt  = r_state;
        o_busy       = (r_state != S_IDLE);
        o_done       = 1'b0;
        o_s_ready    = 1'b0;
        o_m_valid    = w_m_valid;
        o_m_last     = w_m_last;
        o_m_data     = w_m_valid ? w_head : '0;
        o_bram_ena   = w_wr;
        o_bram_wea   = w_wr;
        o_bram_addra = w_wr ? r_wr_cnt[ADDR_WIDTH-1:0] : '0;
        o_bram_dina  = w_wr ? i_s_data : '0;
        o_bram_enb   = w_issue;
        o_bram_web   = 1'b0;
        o_bram_addrb = w_issue ? r_rd_addr[ADDR_WIDTH-1:0] : '0;
        o_bram_dinb  = '0;
        case (r_state)
            S_IDLE: if (i_start) w_state_nxt = S_LOAD;
            S_LOAD: begin
                o_s_ready = 1'b1;
                if (w_wr && (r_wr_cnt == LAST)) w_state_nxt = S_READ;
            end
            S_READ: if (w_pop && w_m_last) w_state_nxt = S_FIN;
            S_FIN: begin
                o_done      = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= S_IDLE;
            r_wr_cnt   <= '0;
            r_rd_addr  <= '0;
            r_out_cnt  <= '0;
            r_inflight <= 1'b0;
            r_fifo     <= '0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_fcnt     <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start_acc) begin
                r_wr_cnt  <= '0;
                r_rd_addr <= '0;
                r_out_cnt <= '0;
            end else begin
                if (w_wr)    r_wr_cnt  <= r_wr_cnt + CW'(1);
                if (w_issue) r_rd_addr <= r_rd_addr + CW'(1);
                if (w_pop)   r_out_cnt <= r_out_cnt + CW'(1);
            end
            // BRAM read data is only meaningful the cycle after an issue.
            r_inflight <= w_issue;
            if (r_inflight) begin
                r_fifo[r_wptr] <= i_bram_doutb;
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) r_rptr <= ~r_rptr;
            r_fcnt <= r_fcnt + 2'(r_inflight) - 2'(w_pop);
        end
    end

`ifdef BRAM_WINDOW_CHKSUM_EN
    logic [DATA_WIDTH-1:0] r_wsum, r_rsum;
    logic                  r_chk_err;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wsum    <= '0;
            r_rsum    <= '0;
            r_chk_err <= 1'b0;
        end else if (w_start_acc) begin
            r_wsum    <= '0;
            r_rsum    <= '0;
            r_chk_err <= 1'b0;
        end else begin
            if (w_wr)  r_wsum <= r_wsum + i_s_data;
            if (w_pop) r_rsum <= r_rsum + w_head;
            if (r_state == S_FIN) r_chk_err <= (r_wsum != r_rsum);
        end
    end

    assign o_chk_err = r_chk_err;
`endif

endmodule

// File: tb/tb_bram_window_ctrl.sv
// Directed bench for bram_window_ctrl with a registered-read BRAM model and handshake logs.
module tb_bram_window_ctrl;
    localparam int DW = 32;
    localparam int AW = 3;
    localparam int WL = 8;

    logic          clk = 1'b0;
    logic          rst, start, s_valid, m_ready;
    logic [DW-1:0] s_data;
    logic          busy, done, s_ready, m_valid, m_last;
    logic [DW-1:0] m_data;
    logic          ena, wea, enb, web;
    logic [AW-1:0] addra, addrb;
    logic [DW-1:0] dina, dinb, doutb;
`ifdef BRAM_WINDOW_CHKSUM_EN
    logic          chk_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bram_window_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WIN_LEN(WL)) dut (
        .i_clk(clk), .i_rst(rst), .i_start(start), .o_busy(busy), .o_done(done),
        .i_s_valid(s_valid), .o_s_ready(s_ready), .i_s_data(s_data),
        .o_m_valid(m_valid), .i_m_ready(m_ready), .o_m_data(m_data), .o_m_last(m_last),
`ifdef BRAM_WINDOW_CHKSUM_EN
        .o_chk_err(chk_err),
`endif
        .o_bram_ena(ena), .o_bram_wea(wea), .o_bram_addra(addra), .o_bram_dina(dina),
        .o_bram_enb(enb), .o_bram_web(web), .o_bram_addrb(addrb), .o_bram_dinb(dinb),
        .i_bram_doutb(doutb)
    );

    // BRAM model: registered read, optional single-word corruption at address 3
    logic [DW-1:0] mem [0:WL-1];
    logic          corrupt = 1'b0;
    always @(posedge clk) begin
        if (ena && wea) mem[addra] <= dina;
        if (enb) doutb <= mem[addrb] ^ ((corrupt && addrb == 3'd3) ? 32'h1 : 32'h0);
    end

    int            cyc = 0;
    int            wa_q[$], wc_q[$], ra_q[$], oc_q[$], dn_q[$];
    logic [DW-1:0] wd_q[$], od_q[$];
    logic          ol_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (ena && wea) begin
            wa_q.push_back(int'(addra));
            wd_q.push_back(dina);
            wc_q.push_back(cyc);
        end
        if (enb) ra_q.push_back(int'(addrb));
        if (m_valid && m_ready) begin
            od_q.push_back(m_data);
            ol_q.push_back(m_last);
            oc_q.push_back(cyc);
        end
        if (done) dn_q.push_back(cyc);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        wa_q.delete(); wc_q.delete(); wd_q.delete(); ra_q.delete();
        od_q.delete(); ol_q.delete(); oc_q.delete(); dn_q.delete();
    endtask

    task automatic load(input logic [31:0] base);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < WL; i++) begin
            s_valid = 1'b1;
            s_data  = base + 32'(i);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (dn_q.size() == 0 && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_done_seen"}, 32'(dn_q.size() != 0), 32'd1);
    endtask

    task automatic chk_win(input string tag, input logic [31:0] base);
        chk({tag, "_nwr"}, wa_q.size(), WL);
        chk({tag, "_nrd"}, ra_q.size(), WL);
        chk({tag, "_nout"}, od_q.size(), WL);
        chk({tag, "_ndone"}, dn_q.size(), 1);
        for (int i = 0; i < WL; i++) begin
            if (i < wa_q.size()) begin
                chk({tag, "_waddr"}, wa_q[i], i);
                chk({tag, "_wdata"}, wd_q[i], base + 32'(i));
            end
            if (i < ra_q.size()) chk({tag, "_raddr"}, ra_q[i], i);
            if (i < od_q.size()) begin
                chk({tag, "_odata"}, od_q[i], base + 32'(i));
                chk({tag, "_olast"}, 32'(ol_q[i]), 32'(i == WL - 1));
            end
        end
    endtask

    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        logic [3:0]    pat;
        int            stalls;

        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);      chk("rst_done", done, 0);
        chk("rst_s_ready", s_ready, 0); chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);  chk("rst_m_data", m_data, 0);
        chk("rst_ena", ena, 0);        chk("rst_wea", wea, 0);
        chk("rst_enb", enb, 0);        chk("rst_addra", 32'(addra), 0);
        chk("rst_addrb", 32'(addrb), 0); chk("rst_dina", dina, 0);
        chk("rst_web", web, 0);        chk("rst_dinb", dinb, 0);
        rst = 1'b0;
        tick();

        // A: ramp 1..8, m_ready held high, full-depth window
        clr();
        m_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        #1;
        chk("a_s_ready_after_start", s_ready, 1);
        chk("a_busy", busy, 1);
        for (int i = 0; i < WL; i++) begin
            s_valid = 1'b1;
            s_data  = 32'(i + 1);
            #1;
            chk("a_ena", ena, 1);
            chk("a_addra", 32'(addra), i);
            tick();
        end
        s_valid = 1'b0;
        #1;
        chk("a_s_ready_low", s_ready, 0);
        wait_done("a");
        chk_win("a", 32'd1);
        if (oc_q.size() == WL && wc_q.size() == WL && dn_q.size() == 1) begin
            chk("a_first_out_cyc", oc_q[0], wc_q[WL-1] + 3);
            for (int i = 1; i < WL; i++) chk("a_out_consec", oc_q[i], oc_q[0] + i);
            chk("a_done_cyc", dn_q[0], oc_q[WL-1] + 1);
        end
        tick();
        chk("a_busy_idle", busy, 0);
        chk("a_done_low", done, 0);
`ifdef BRAM_WINDOW_CHKSUM_EN
        chk("a_chk_err", chk_err, 0);
`endif

        // B: gapped input, 9th sample offered, start pulses, m_ready 1,0,0,1
        clr();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < WL; i++) begin
            for (int s = 0; s < 3; s++) begin
                s_valid = (s == 2);
                s_data  = 32'(11 + i);
                start   = (i == 3 && s == 1);
                tick();
            end
        end
        start   = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'd99;
        #1;
        chk("b_s_ready_low", s_ready, 0);
        chk("b_no_9th_write", ena, 0);
        pat = 4'b1001;
        prev_stall = 1'b0; prev_data = '0; prev_last = 1'b0; stalls = 0;
        for (int k = 0; k < 80 && dn_q.size() == 0; k++) begin
            m_ready = pat[k % 4];
            start   = (k == 2);
            #2;
            if (prev_stall) begin
                stalls++;
                chk("b_stall_data", m_data, prev_data);
                chk("b_stall_last", m_last, prev_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
            tick();
        end
        start   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        chk("b_done_seen", 32'(dn_q.size() != 0), 32'd1);
        chk("b_saw_stalls", 32'(stalls > 0), 32'd1);
        chk_win("b", 32'd11);
        repeat (3) tick();
        chk("b_busy_idle", busy, 0);
        chk("b_no_extra_writes", wa_q.size(), WL);

        // C: reset mid-READ, then a clean window
        clr();
        m_ready = 1'b0;
        load(32'd21);
        repeat (2) tick();
        chk("c_m_valid_pre", m_valid, 1);
        rst = 1'b1;
        #1;
        chk("c_busy", busy, 0);        chk("c_m_valid", m_valid, 0);
        chk("c_m_data", m_data, 0);    chk("c_m_last", m_last, 0);
        chk("c_enb", enb, 0);          chk("c_addrb", 32'(addrb), 0);
        chk("c_s_ready", s_ready, 0);  chk("c_done", done, 0);
        tick();
        rst = 1'b0;
        tick();
        clr();
        m_ready = 1'b1;
        load(32'd31);
        wait_done("c");
        chk_win("c", 32'd31);
        tick();

`ifdef BRAM_WINDOW_CHKSUM_EN
        // D: corrupted read word must raise chk_err after FIN
        clr();
        corrupt = 1'b1;
        load(32'd41);
        wait_done("d");
        corrupt = 1'b0;
        chk("d_chk_err", chk_err, 1);
        if (od_q.size() == WL) begin
            chk("d_word3", od_q[3], 32'd44 ^ 32'd1);
            chk("d_word2", od_q[2], 32'd43);
        end
        clr();
        load(32'd51);
        #1;
        chk("d_chk_clear_on_start", chk_err, 0);
        wait_done("e");
        chk("e_chk_err", chk_err, 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
